// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the shared serial datapath.
// Ports: a, b, c in; sum, carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: start/done handshake, WIDTH-cycle add.
// Ports: clk, rst_n, start, a, b, cin in; ready, busy, done, sum, cout out.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be 2..32");
  end

  state_t           state;
  logic [WIDTH-1:0] sreg_a;
  logic [WIDTH-1:0] sreg_b;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_nxt;

  full_adder u_fa (
    .a     (sreg_a[0]),
    .b     (sreg_b[0]),
    .c     (carry),
    .sum   (fa_s),
    .carry (fa_c)
  );

  // Includes the bit produced this cycle so the last bit lands in sum.
  assign sum_nxt = {fa_s, sum_sh[WIDTH-1:1]};

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sreg_a <= '0;
      sreg_b <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sreg_a <= a;
            sreg_b <= b;
            carry  <= cin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          sreg_a <= sreg_a >> 1;
          sreg_b <= sreg_b >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            sum   <= sum_nxt;
            cout  <= fa_c;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8.
// Drives on negedge, checks results and latency on negedge.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_done = 0;
  int   sum_chg = 0;
  logic [W-1:0] prev_sum = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (sum !== prev_sum) sum_chg++;
    prev_sum = sum;
    if (rst_n && done) begin
      n_done++;
      if (q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] ea,
                          input logic [W-1:0] eb,
                          input logic ec,
                          input int dcyc);
    exp_t e;
    logic [W:0] r;
    r = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    e.sum = r[W-1:0];
    e.cout = r[W];
    e.cyc = dcyc;
    q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] ia,
                       input logic [W-1:0] ib,
                       input logic ic);
    @(negedge clk);
    wait_ready();
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    push_exp(ia, ib, ic, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(q.size()), 0);
  endtask

  initial begin
    int base;
    int nd;
    logic rdy_seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #12;
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'h5A, 8'h3C, 1'b0);
    check("busy_run", 32'(busy), 1);
    drain();
    issue(8'hFF, 8'h01, 1'b0);
    drain();
    issue(8'hFF, 8'hFF, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      issue(ra, rb, 1'($urandom));
      drain();
    end
    issue(8'hFF, 8'hFF, 1'b1);
    drain();

    // start mid-RUN must be ignored
    sum_chg = 0;
    nd = n_done;
    issue(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    cin = 1'b1;
    start = 1'b1;
    rdy_seen = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (ready && (q.size() != 0)) rdy_seen = 1'b1;
      @(negedge clk);
    end
    check("mid_ready_low", 32'(rdy_seen), 0);
    check("mid_one_done", n_done - nd, 1);
    check("mid_sum_chg", sum_chg, 1);
    check("mid_q_empty", 32'(q.size()), 0);

    // reset mid-RUN
    nd = n_done;
    issue(8'h77, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(sum), 0);
    check("arst_cout", 32'(cout), 0);
    check("arst_ready", 32'(ready), 1);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("arst_no_done", n_done - nd, 0);
    issue(8'h01, 8'h01, 1'b0);
    drain();

    // start held high across three operations
    @(negedge clk);
    wait_ready();
    base = cyc + 1 + W;
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] oa;
      logic [W-1:0] ob;
      logic         oc;
      oa = (i == 0) ? 8'h10 : (i == 1) ? 8'h80 : 8'h00;
      ob = (i == 0) ? 8'h20 : (i == 1) ? 8'h80 : 8'h00;
      oc = (i == 2);
      if (i != 0) wait_ready();
      a = oa;
      b = ob;
      cin = oc;
      start = 1'b1;
      push_exp(oa, ob, oc, base + 10 * i);
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    // long idle after reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    nd = n_done;
    rdy_seen = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!ready || sum !== '0 || cout !== 1'b0) rdy_seen = 1'b0;
    end
    check("idle_stable", 32'(rdy_seen), 1);
    check("idle_no_done", n_done - nd, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
